reg_scoreboard: RTL and testbench

- Producer-side hazard tracker for the 5-stage core. Records in-flight register writes issued from ID and raises a stall when an ID-stage instruction reads or overwrites a register whose value forwarding cannot yet supply.
- Covers load-use hazards (fixed countdown) and long-latency ops such as mul/div (busy until a completion pulse).
- Sits beside the decode stage and complements the EX-stage forwarding logic.

---
 rtl/reg_scoreboard.sv | 104 ++++++++++
 tb/tb_reg_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - ID-stage register hazard scoreboard for load-use and long-latency producers.
// Optional SCOREBOARD_PERF_EN adds the free-running stall_cnt output.
module reg_scoreboard #(
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic                     id_flush,
    input  logic [$clog2(NREG)-1:0]  id_rs1_idx,
    input  logic [$clog2(NREG)-1:0]  id_rs2_idx,
    input  logic                     id_use_rs1,
    input  logic                     id_use_rs2,
    input  logic                     id_regWrite,
    input  logic [$clog2(NREG)-1:0]  id_rd_idx,
    input  logic                     id_is_load,
    input  logic                     id_is_long,
    input  logic                     lc_valid,
    input  logic [$clog2(NREG)-1:0]  lc_rd_idx,
    output logic                     stall,
    output logic [NREG-1:0]          busy_vec
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int IW = $clog2(NREG);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  long_q, long_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic             rs1_hz, rs2_hz, raw, waw, issue;

    assign rs1_hz = (id_rs1_idx != '0) && ((cnt_q[id_rs1_idx] != '0) || long_q[id_rs1_idx]);
    assign rs2_hz = (id_rs2_idx != '0) && ((cnt_q[id_rs2_idx] != '0) || long_q[id_rs2_idx]);
    assign raw    = (id_use_rs1 && rs1_hz) || (id_use_rs2 && rs2_hz);
    assign waw    = id_regWrite && id_is_long && (id_rd_idx != '0) && long_q[id_rd_idx];

    // Gated by rst_n so the core never sees a stall while the state is being cleared.
    assign stall  = rst_n && id_valid && !id_flush && (raw || waw);
    assign issue  = id_valid && !id_flush && !stall && id_regWrite && (id_rd_idx != '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r]  = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
            long_d[r] = long_q[r];
            if (lc_valid && (lc_rd_idx == IW'(r))) begin
                long_d[r] = 1'b0;
            end
            // Issue is applied after completion so a same-cycle issue to rd wins.
            if (issue && (id_rd_idx == IW'(r))) begin
                if (id_is_long) begin
                    long_d[r] = 1'b1;
                end else if (id_is_load) begin
                    cnt_d[r] = CNT_W'(LOAD_LAT);
                end else begin
                    cnt_d[r] = '0;
                end
            end
            if (r == 0) begin
                cnt_d[r]  = '0;
                long_d[r] = 1'b0;
            end
            busy_d[r] = (cnt_d[r] != '0) || long_d[r];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            long_q <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            long_q <= long_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard at LOAD_LAT=1 and LOAD_LAT=2.
module tb_reg_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, id_valid, id_flush, id_use_rs1, id_use_rs2, id_regWrite;
    logic       id_is_load, id_is_long, lc_valid;
    logic [4:0] id_rs1_idx, id_rs2_idx, id_rd_idx, lc_rd_idx;
    logic       st [2];
    logic [31:0] bv [2];
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] sc [2];
`endif

    reg_scoreboard #(.NREG(32), .LOAD_LAT(1), .CNT_W(2)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regWrite(id_regWrite), .id_rd_idx(id_rd_idx),
        .id_is_load(id_is_load), .id_is_long(id_is_long),
        .lc_valid(lc_valid), .lc_rd_idx(lc_rd_idx),
        .stall(st[0]), .busy_vec(bv[0])
`ifdef SCOREBOARD_PERF_EN
        , .stall_cnt(sc[0])
`endif
    );

    reg_scoreboard #(.NREG(32), .LOAD_LAT(2), .CNT_W(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regWrite(id_regWrite), .id_rd_idx(id_rd_idx),
        .id_is_load(id_is_load), .id_is_long(id_is_long),
        .lc_valid(lc_valid), .lc_rd_idx(lc_rd_idx),
        .stall(st[1]), .busy_vec(bv[1])
`ifdef SCOREBOARD_PERF_EN
        , .stall_cnt(sc[1])
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a load makes rd unavailable until a known cycle number; long ops are a pending set.
    int          m_ready [2][32];
    bit          m_long  [2][32];
    int unsigned m_scnt  [2];
    int          m_lat   [2] = '{1, 2};
    int          m_cyc = 0;

    function automatic bit m_pend(input int k, input int r);
        return (r != 0) && ((m_cyc < m_ready[k][r]) || m_long[k][r]);
    endfunction

    function automatic bit m_stall(input int k);
        bit raw, waw;
        raw = (id_use_rs1 && m_pend(k, int'(id_rs1_idx))) || (id_use_rs2 && m_pend(k, int'(id_rs2_idx)));
        waw = id_regWrite && id_is_long && (id_rd_idx != 0) && m_long[k][id_rd_idx];
        return rst_n && id_valid && !id_flush && (raw || waw);
    endfunction

    always @(negedge clk) begin
        logic [31:0] eb;
        bit s, iss;
        for (int k = 0; k < 2; k++) begin
            eb = '0;
            for (int r = 0; r < 32; r++) eb[r] = m_pend(k, r);
            chk(k == 0 ? "model_stall_lat1" : "model_stall_lat2", {31'd0, st[k]}, {31'd0, m_stall(k)});
            chk(k == 0 ? "model_busy_lat1" : "model_busy_lat2", bv[k], eb);
`ifdef SCOREBOARD_PERF_EN
            chk(k == 0 ? "model_scnt_lat1" : "model_scnt_lat2", sc[k], m_scnt[k]);
`endif
        end
        for (int k = 0; k < 2; k++) begin
            s   = m_stall(k);
            iss = !s && rst_n && id_valid && !id_flush && id_regWrite && (id_rd_idx != 0);
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) begin
                    m_ready[k][r] = 0;
                    m_long[k][r]  = 1'b0;
                end
                m_scnt[k] = 0;
            end else begin
                if (lc_valid && lc_rd_idx != 0) m_long[k][lc_rd_idx] = 1'b0;
                if (iss) begin
                    if (id_is_long)      m_long[k][id_rd_idx]  = 1'b1;
                    else if (id_is_load) m_ready[k][id_rd_idx] = m_cyc + m_lat[k] + 1;
                    else                 m_ready[k][id_rd_idx] = 0;
                end
                if (s) m_scnt[k]++;
            end
        end
        m_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_flush = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regWrite = 0;
        id_is_load = 0; id_is_long = 0; lc_valid = 0;
        id_rs1_idx = 0; id_rs2_idx = 0; id_rd_idx = 0; lc_rd_idx = 0;
    endtask

    task automatic issue_op(input logic [4:0] rd, input logic ld, input logic lng);
        idle();
        id_valid = 1; id_regWrite = 1; id_rd_idx = rd; id_is_load = ld; id_is_long = lng;
    endtask

    int c0, c1, held;

    initial begin
        rst_n = 0;
        idle();
        repeat (2) tick();
        rst_n = 1;

        id_valid = 1; id_use_rs1 = 1; id_rs1_idx = 5;
        @(negedge clk);
        chk("reset_stall", {31'd0, st[0]}, 32'd0);
        chk("reset_busy", bv[0], 32'd0);
        tick();

        issue_op(5, 1, 0);
        tick();
        idle(); id_valid = 1; id_use_rs1 = 1; id_rs1_idx = 5;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("load_busy5", {31'd0, bv[0][5]}, 32'd1);
            c0 += int'(st[0]);
            c1 += int'(st[1]);
            tick();
        end
        chk("load_use_cycles_lat1", c0, 1);
        chk("load_use_cycles_lat2", c1, 2);

        issue_op(7, 1, 1);
        tick();
        idle(); id_valid = 1; id_use_rs2 = 1; id_rs2_idx = 7;
        held = 0;
        repeat (10) begin
            @(negedge clk);
            held += int'(st[0] && st[1]);
            tick();
        end
        chk("long_held_cycles", held, 10);
        lc_valid = 1; lc_rd_idx = 7;
        @(negedge clk);
        chk("long_stall_at_lc", {31'd0, st[0]}, 32'd1);
        tick();
        lc_valid = 0;
        @(negedge clk);
        chk("long_stall_after_lc", {31'd0, st[0]}, 32'd0);
        chk("long_busy7_cleared", {31'd0, bv[0][7]}, 32'd0);
        tick();

        issue_op(7, 0, 1);
        tick();
        held = 0;
        repeat (3) begin
            @(negedge clk);
            held += int'(st[0]);
            tick();
        end
        chk("waw_held_cycles", held, 3);
        lc_valid = 1; lc_rd_idx = 7;
        @(negedge clk);
        chk("waw_stall_at_lc", {31'd0, st[0]}, 32'd1);
        tick();
        lc_valid = 0;
        @(negedge clk);
        chk("waw_issue_after_lc", {31'd0, st[0]}, 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("waw_busy7_reset", {31'd0, bv[0][7]}, 32'd1);
        lc_valid = 1; lc_rd_idx = 7;
        tick();

        issue_op(10, 0, 1);
        lc_valid = 1; lc_rd_idx = 10;
        tick();
        idle();
        @(negedge clk);
        chk("issue_beats_completion", {31'd0, bv[0][10]}, 32'd1);
        lc_valid = 1; lc_rd_idx = 10;
        tick();

        issue_op(0, 1, 1);
        tick();
        idle(); id_valid = 1; id_use_rs1 = 1; id_use_rs2 = 1; id_regWrite = 1; id_is_long = 1;
        @(negedge clk);
        chk("x0_no_stall", {31'd0, st[0]}, 32'd0);
        chk("x0_busy_zero", bv[0], 32'd0);
        tick();

        issue_op(5, 1, 0);
        tick();
        issue_op(6, 1, 0);
        id_use_rs1 = 1; id_rs1_idx = 5; id_flush = 1;
        @(negedge clk);
        chk("flush_no_stall", {31'd0, st[1]}, 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("flush_no_issue6", {31'd0, bv[1][6]}, 32'd0);
        tick();

        issue_op(5, 1, 0);
        tick();
        idle(); rst_n = 0; id_valid = 1; id_use_rs1 = 1; id_rs1_idx = 5;
        @(negedge clk);
        chk("reset_mid_stall", {31'd0, st[1]}, 32'd0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("reset_mid_busy", bv[1], 32'd0);
        chk("reset_mid_no_stall", {31'd0, st[1]}, 32'd0);
`ifdef SCOREBOARD_PERF_EN
        chk("reset_mid_stall_cnt", sc[1], 32'd0);
`endif
        tick();
        idle(); lc_valid = 1; lc_rd_idx = 7;
        tick();
        idle();
        @(negedge clk);
        chk("late_lc_no_effect", bv[0], 32'd0);
        tick();

        for (int i = 0; i < 300; i++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_flush    = ($urandom_range(0, 7) == 0);
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            id_regWrite = 1'($urandom_range(0, 1));
            id_is_load  = 1'($urandom_range(0, 1));
            id_is_long  = ($urandom_range(0, 3) == 0);
            id_rs1_idx  = 5'($urandom_range(0, 7));
            id_rs2_idx  = 5'($urandom_range(0, 7));
            id_rd_idx   = 5'($urandom_range(0, 7));
            lc_valid    = ($urandom_range(0, 2) == 0);
            lc_rd_idx   = 5'($urandom_range(0, 7));
            tick();
        end

        idle();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
